// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        BR_REDIRECT_00 = 2'b00,
        BR_REDIRECT_10 = 2'b10
    } branch_op_e;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    // True for the two BranchOp codes that also flush IF/ID.
    function automatic logic is_redirect(input logic [1:0] op);
        return (op == 2'(BR_REDIRECT_00)) || (op == 2'(BR_REDIRECT_10));
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel between fetch (master) and memory (slave).
interface fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, insn} entries; clear wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  fetch_entry_t                 entry_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;

    assign do_push = push_i && !clear_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i  && !clear_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, in-order imem requests, fetch buffer, redirect/drain.
// Optional FETCH_PERF_EN adds perf_fetched / perf_redirects counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  BranchOp,
    input  logic [31:0] branch_target,
    fetch_if.master     imem,
    output logic [31:0] PC_Out,
    output logic [31:0] instruction,
    output logic        if_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects
`endif
);

    localparam int unsigned CW = $clog2(FBUF_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_entry;
    logic          fifo_push, fifo_pop, fifo_clear;
    logic          redirect, credit, req_valid_c, req_fire, rsp_fire;

    assign redirect = is_redirect(BranchOp);
    assign credit   = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW + 1)'(FBUF_DEPTH);

    assign req_valid_c = !rst && (state_q == RUN) && credit;
    assign req_fire    = req_valid_c && imem.imem_req_ready;
    assign rsp_fire    = imem.imem_rsp_valid;

    assign imem.imem_req_valid = req_valid_c;
    assign imem.imem_req_addr  = fetch_pc_q;

    assign fifo_entry = '{pc: rsp_pc_q, insn: imem.imem_rsp_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Next-state: sequential fetch in RUN, discard stale responses in DRAIN, redirect overrides.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_clear    = 1'b0;
        inflight      = outstanding_q + CW'(req_fire) - CW'(rsp_fire);

        case (state_q)
            RUN: begin
                if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
                if (rsp_fire) begin
                    fifo_push = 1'b1;
                    rsp_pc_d  = rsp_pc_q + 32'd4;
                end
                outstanding_d = inflight;
                fifo_pop      = if_valid && !stall;
            end
            DRAIN: begin
                if (rsp_fire) begin
                    drop_cnt_d    = drop_cnt_q - CW'(1);
                    outstanding_d = outstanding_q - CW'(1);
                    if (drop_cnt_q == CW'(1)) state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        // A response arriving with the redirect is already excluded from inflight.
        if (redirect) begin
            fetch_pc_d = branch_target;
            rsp_pc_d   = branch_target;
            fifo_clear = 1'b1;
            fifo_push  = 1'b0;
            fifo_pop   = 1'b0;
            if (state_q == RUN) begin
                drop_cnt_d    = inflight;
                outstanding_d = inflight;
                state_d       = (inflight != '0) ? DRAIN : RUN;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FBUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .entry_i (fifo_entry),
        .pop_i   (fifo_pop),
        .clear_i (fifo_clear),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign if_valid    = (fifo_count != '0);
    assign instruction = if_valid ? fifo_head.insn : NOP_INSN;
    assign PC_Out      = if_valid ? fifo_head.pc   : 32'h0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_redirects_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q   <= '0;
            perf_redirects_q <= '0;
        end else begin
            if (fifo_pop) perf_fetched_q   <= perf_fetched_q + 32'd1;
            if (redirect) perf_redirects_q <= perf_redirects_q + 32'd1;
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule
